// File: rtl/message_retransmitter.sv
// message_retransmitter
// Stop-and-wait control stage in front of the TX framer. It accepts one
// message at a time and offers it as {seq, payload}. It holds the message
// timer in reset except while waiting for an ack. A timer irq causes a
// retransmission, until MAX_RETRIES retransmissions have been sent. It pulses
// done on a matching ack, or fail when the retries are used up.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   msg_valid/ready     upstream message handshake, msg_data payload
//   tx_valid/ready      frame handshake to TX framer, tx_data = {seq, payload}
//   ack_valid, ack_seq  ack pulse from the link and its sequence bit
//   timer_reset         active-high reset to message_timer
//   timer_irq           message_timer timeout pulse
//   done, fail          one-cycle result pulses (registered)
//   retry_count         retransmissions of the current message so far
module message_retransmitter #(
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_RETRIES = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  msg_valid,
   input  logic [DATA_WIDTH-1:0] msg_data,
   output logic                  msg_ready,
   output logic                  tx_valid,
   output logic [DATA_WIDTH:0]   tx_data,
   input  logic                  tx_ready,
   input  logic                  ack_valid,
   input  logic                  ack_seq,
   output logic                  timer_reset,
   input  logic                  timer_irq,
   output logic                  done,
   output logic                  fail,
   output logic [7:0]            retry_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

   state_t                state_r;
   state_t                state_s;
   logic                  seq_r;
   logic [DATA_WIDTH-1:0] payload_r;
   logic [7:0]            retry_count_r;
   logic                  done_r;
   logic                  fail_r;

   logic                  accept_s;
   logic                  done_s;
   logic                  fail_s;
   logic                  retry_s;
   logic                  ready_dec_s;
   logic                  valid_dec_s;
   logic                  timer_run_s;

   // Next-state logic, transfer events and state decode of the handshake outputs
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      done_s      = 1'b0;
      fail_s      = 1'b0;
      retry_s     = 1'b0;
      ready_dec_s = 1'b0;
      valid_dec_s = 1'b0;
      timer_run_s = 1'b0;
      case (state_r)
         IDLE: begin
            ready_dec_s = 1'b1;
            if (msg_valid) begin
               accept_s = 1'b1;
               state_s  = SEND;
            end else begin
               state_s  = IDLE;
            end
         end
         SEND: begin
            valid_dec_s = 1'b1;
            if (tx_ready) begin
               state_s = WAIT_ACK;
            end else begin
               state_s = SEND;
            end
         end
         WAIT_ACK: begin
            timer_run_s = 1'b1;
            // A matching ack takes priority over a coincident timeout
            if (ack_valid && (ack_seq == seq_r)) begin
               done_s  = 1'b1;
               state_s = IDLE;
            end else if (timer_irq) begin
               if (retry_count_r < MAX_R) begin
                  retry_s = 1'b1;
                  state_s = SEND;
               end else begin
                  fail_s  = 1'b1;
                  state_s = IDLE;
               end
            end else begin
               state_s = WAIT_ACK;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, sequence bit, payload, retry counter and result pulse registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= IDLE;
         seq_r         <= 1'b0;
         payload_r     <= '0;
         retry_count_r <= 8'd0;
         done_r        <= 1'b0;
         fail_r        <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= done_s;
         fail_r  <= fail_s;
         if (accept_s) begin
            payload_r     <= msg_data;
            retry_count_r <= 8'd0;
         end else if (retry_s) begin
            retry_count_r <= retry_count_r + 8'd1;
         end else begin
            retry_count_r <= retry_count_r;
         end
         // The sequence bit only moves on to the next message once this one has resolved
         if (done_s || fail_s) begin
            seq_r <= ~seq_r;
         end else begin
            seq_r <= seq_r;
         end
      end
   end

   // While reset is held low the handshakes stay closed and the timer stays cleared
   assign msg_ready   = reset & ready_dec_s;
   assign tx_valid    = reset & valid_dec_s;
   assign timer_reset = ~(reset & timer_run_s);
   assign tx_data     = {seq_r, payload_r};
   assign done        = done_r;
   assign fail        = fail_r;
   assign retry_count = retry_count_r;

endmodule

// File: tb/tb_message_retransmitter.sv
// Directed testbench for message_retransmitter (DATA_WIDTH=8, MAX_RETRIES=3).
// Inputs change 1 time unit after each rising edge. Outputs are sampled at that
// same point, away from the active edge.
module tb_message_retransmitter;

   logic       clock;
   logic       reset;
   logic       msg_valid;
   logic [7:0] msg_data;
   logic       msg_ready;
   logic       tx_valid;
   logic [8:0] tx_data;
   logic       tx_ready;
   logic       ack_valid;
   logic       ack_seq;
   logic       timer_reset;
   logic       timer_irq;
   logic       done;
   logic       fail;
   logic [7:0] retry_count;

   int vectors = 0;
   int errors  = 0;
   int tx_count = 0;
   int tx_start;
   int done_seen;
   int fail_seen;

   message_retransmitter #(.DATA_WIDTH(8), .MAX_RETRIES(3)) dut (
      .clock(clock), .reset(reset),
      .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .ack_valid(ack_valid), .ack_seq(ack_seq),
      .timer_reset(timer_reset), .timer_irq(timer_irq),
      .done(done), .fail(fail), .retry_count(retry_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count completed frame handshakes
   always @(posedge clock) begin
      if (reset && tx_valid && tx_ready) tx_count <= tx_count + 1;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; msg_valid = 1'b0; msg_data = 8'h00; tx_ready = 1'b0;
      ack_valid = 1'b0; ack_seq = 1'b0; timer_irq = 1'b0;
      step(); step();
      vectors++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL rst_msg_ready got %b exp 0", msg_ready); end
      vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
      vectors++; if (timer_reset !== 1'b1) begin errors++; $display("FAIL rst_timer_reset got %b exp 1", timer_reset); end
      vectors++; if ({done, fail} !== 2'b00) begin errors++; $display("FAIL rst_done_fail got %b exp 00", {done, fail}); end
      vectors++; if (retry_count !== 8'd0) begin errors++; $display("FAIL rst_retry got %0d exp 0", retry_count); end
      vectors++; if (tx_data !== 9'h000) begin errors++; $display("FAIL rst_tx_data got %h exp 000", tx_data); end
      reset = 1'b1;
      #1;
      vectors++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", msg_ready); end
   endtask

   task automatic test_basic();
      msg_valid = 1'b1; msg_data = 8'hA5; tx_ready = 1'b1;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 9'h0A5) begin errors++; $display("FAIL basic_tx got v=%b d=%h exp v=1 d=0a5", tx_valid, tx_data); end
      vectors++; if (msg_ready !== 1'b0 || timer_reset !== 1'b1) begin errors++; $display("FAIL basic_send_ctl got rdy=%b tr=%b exp 0 1", msg_ready, timer_reset); end
      step();
      for (int i = 0; i < 4; i++) begin
         vectors++; if (tx_valid !== 1'b0 || timer_reset !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_wait%0d got v=%b tr=%b done=%b exp 0 0 0", i, tx_valid, timer_reset, done); end
         step();
      end
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
      vectors++; if (done !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b fail=%b exp 1 0", done, fail); end
      vectors++; if (retry_count !== 8'd0 || msg_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got retry=%0d rdy=%b exp 0 1", retry_count, msg_ready); end
      // Second message goes out with seq 1
      msg_valid = 1'b1; msg_data = 8'h3C;
      step();
      msg_valid = 1'b0;
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", done); end
      vectors++; if (tx_data !== 9'h13C) begin errors++; $display("FAIL basic_seq1 got %h exp 13c", tx_data); end
      step();
      ack_valid = 1'b1; ack_seq = 1'b1;
      step();
      ack_valid = 1'b0;
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done2 got %b exp 1", done); end
   endtask

   task automatic test_retries();
      tx_start = tx_count;
      fail_seen = 0;
      msg_valid = 1'b1; msg_data = 8'hA5; tx_ready = 1'b1;
      step();
      msg_valid = 1'b0;
      step();
      for (int r = 1; r <= 2; r++) begin
         step(); step();
         timer_irq = 1'b1;
         step();
         timer_irq = 1'b0;
         vectors++; if (tx_valid !== 1'b1 || tx_data !== 9'h0A5 || timer_reset !== 1'b1) begin errors++; $display("FAIL retry%0d_tx got v=%b d=%h tr=%b exp 1 0a5 1", r, tx_valid, tx_data, timer_reset); end
         vectors++; if (retry_count !== 8'(r)) begin errors++; $display("FAIL retry%0d_count got %0d exp %0d", r, retry_count, r); end
         step();
      end
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
      if (fail) fail_seen++;
      vectors++; if (done !== 1'b1 || fail_seen !== 0) begin errors++; $display("FAIL retry_done got done=%b fail=%0d exp 1 0", done, fail_seen); end
      vectors++; if (retry_count !== 8'd2) begin errors++; $display("FAIL retry_final got %0d exp 2", retry_count); end
      vectors++; if (tx_count - tx_start !== 3) begin errors++; $display("FAIL retry_tx_count got %0d exp 3", tx_count - tx_start); end
   endtask

   task automatic test_exhaustion();
      tx_start = tx_count;
      done_seen = 0;
      msg_valid = 1'b1; msg_data = 8'h5A;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_data !== 9'h15A) begin errors++; $display("FAIL exh_first got %h exp 15a", tx_data); end
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         if (done) done_seen++;
         vectors++; if (fail !== 1'b0) begin errors++; $display("FAIL exh_early_fail%0d got %b exp 0", k, fail); end
         timer_irq = 1'b1;
         step();
         timer_irq = 1'b0;
         if (k < 3) step();
      end
      vectors++; if (fail !== 1'b1 || done !== 1'b0 || done_seen !== 0) begin errors++; $display("FAIL exh_fail got fail=%b done=%b exp 1 0", fail, done); end
      vectors++; if (retry_count !== 8'd3 || msg_ready !== 1'b1) begin errors++; $display("FAIL exh_idle got retry=%0d rdy=%b exp 3 1", retry_count, msg_ready); end
      vectors++; if (tx_count - tx_start !== 4) begin errors++; $display("FAIL exh_tx_count got %0d exp 4", tx_count - tx_start); end
      step();
      vectors++; if (fail !== 1'b0) begin errors++; $display("FAIL exh_fail_width got %b exp 0", fail); end
      // The next message uses seq 0 after the fail toggled it
      msg_valid = 1'b1; msg_data = 8'h77;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_data !== 9'h077 || retry_count !== 8'd0) begin errors++; $display("FAIL exh_next got d=%h retry=%0d exp 077 0", tx_data, retry_count); end
      step();
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
   endtask

   task automatic test_stale_collision();
      tx_start = tx_count;
      msg_valid = 1'b1; msg_data = 8'h42;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_data !== 9'h142) begin errors++; $display("FAIL stale_tx got %h exp 142", tx_data); end
      step();
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
      vectors++; if (done !== 1'b0 || timer_reset !== 1'b0 || msg_ready !== 1'b0) begin errors++; $display("FAIL stale_ignored got done=%b tr=%b rdy=%b exp 0 0 0", done, timer_reset, msg_ready); end
      ack_valid = 1'b1; ack_seq = 1'b1; timer_irq = 1'b1;
      step();
      ack_valid = 1'b0; timer_irq = 1'b0;
      vectors++; if (done !== 1'b1 || tx_valid !== 1'b0 || retry_count !== 8'd0) begin errors++; $display("FAIL collide got done=%b v=%b retry=%0d exp 1 0 0", done, tx_valid, retry_count); end
      vectors++; if (tx_count - tx_start !== 1) begin errors++; $display("FAIL collide_tx_count got %0d exp 1", tx_count - tx_start); end
   endtask

   task automatic test_backpressure();
      tx_start = tx_count;
      tx_ready = 1'b0;
      msg_valid = 1'b1; msg_data = 8'h99;
      step();
      msg_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (tx_valid !== 1'b1 || tx_data !== 9'h099 || timer_reset !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h tr=%b exp 1 099 1", i, tx_valid, tx_data, timer_reset); end
         timer_irq = (i == 1);
         step();
         timer_irq = 1'b0;
      end
      vectors++; if (tx_valid !== 1'b1 || retry_count !== 8'd0) begin errors++; $display("FAIL bp_irq_ignored got v=%b retry=%0d exp 1 0", tx_valid, retry_count); end
      tx_ready = 1'b1;
      step();
      vectors++; if (tx_valid !== 1'b0 || timer_reset !== 1'b0) begin errors++; $display("FAIL bp_wait got v=%b tr=%b exp 0 0", tx_valid, timer_reset); end
      vectors++; if (tx_count - tx_start !== 1) begin errors++; $display("FAIL bp_tx_count got %0d exp 1", tx_count - tx_start); end
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
   endtask

   task automatic test_reset_mid_wait();
      msg_valid = 1'b1; msg_data = 8'h11;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_data !== 9'h111) begin errors++; $display("FAIL rmw_tx got %h exp 111", tx_data); end
      step();
      step();
      reset = 1'b0;
      step();
      vectors++; if (done !== 1'b0 || fail !== 1'b0 || timer_reset !== 1'b1 || msg_ready !== 1'b0) begin errors++; $display("FAIL rmw_held got done=%b fail=%b tr=%b rdy=%b exp 0 0 1 0", done, fail, timer_reset, msg_ready); end
      reset = 1'b1;
      #1;
      vectors++; if (msg_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL rmw_release got rdy=%b v=%b exp 1 0", msg_ready, tx_valid); end
      step();
      vectors++; if (done !== 1'b0 || fail !== 1'b0) begin errors++; $display("FAIL rmw_no_pulse got done=%b fail=%b exp 0 0", done, fail); end
      msg_valid = 1'b1; msg_data = 8'h22;
      step();
      msg_valid = 1'b0;
      vectors++; if (tx_data !== 9'h022) begin errors++; $display("FAIL rmw_seq0 got %h exp 022", tx_data); end
      step();
      ack_valid = 1'b1; ack_seq = 1'b0;
      step();
      ack_valid = 1'b0;
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rmw_done got %b exp 1", done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_retries();
      test_exhaustion();
      test_stale_collision();
      test_backpressure();
      test_reset_mid_wait();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
